// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider for signed and unsigned DIV/DIVU.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED_OP,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             DIV_ZERO
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] q_out_q, q_out_d, r_out_q, r_out_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d;
  logic busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [WIDTH:0] rem_sh, diff;
  always_comb begin
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    busy_d  = busy_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (START) begin
        quo_d   = (SIGNED_OP && DIVIDEND[WIDTH-1]) ? -DIVIDEND : DIVIDEND;
        dvs_d   = (SIGNED_OP && DIVISOR[WIDTH-1]) ? -DIVISOR : DIVISOR;
        rem_d   = '0;
        qneg_d  = SIGNED_OP & (DIVIDEND[WIDTH-1] ^ DIVISOR[WIDTH-1]);
        rneg_d  = SIGNED_OP & DIVIDEND[WIDTH-1];
        zero_d  = (DIVISOR == '0);
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        rem_d   = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : CALC;
      end
      FIX: begin
        // Negating the dividend magnitude restores the raw dividend, which covers the divide-by-zero remainder.
        q_out_d = zero_q ? '1 : (qneg_q ? -quo_q : quo_q);
        r_out_d = rneg_q ? -rem_q : rem_q;
        dz_d    = zero_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      q_out_q <= '0;
      r_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign QUOTIENT  = q_out_q;
  assign REMAINDER = r_out_q;
  assign DIV_ZERO  = dz_q;
endmodule
